// File: rtl/inst_rom_resp_pkg.sv
// Shared bus widths, the NOP word and FSM state encodings for the instruction ROM responder.
package inst_rom_resp_pkg;

    localparam int unsigned INST_W      = 32;
    localparam int unsigned INST_ADDR_W = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

endpackage

// File: rtl/inst_rom_resp_ram.sv
// Instruction storage: 2^AW x 32, one synchronous write port and one asynchronous read port.
module inst_ram
    import inst_rom_resp_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction memory front end: clears itself after reset, serves zero-latency fetches,
// and accepts program-load bursts that overwrite words starting at a given base.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_en,
    input  logic [INST_ADDR_W-1:0] rom_addr,
    output logic [INST_W-1:0]      rom_data,
    output logic                   cpu_hold,
    input  logic                   ld_start,
    input  logic [AW-1:0]          ld_base,
    input  logic                   ld_valid,
    input  logic [INST_W-1:0]      ld_data,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   ld_done,
    output logic                   oob_err
);

    // Address bits above the word index must be zero for an in-range fetch.
    localparam logic [INST_ADDR_W-1:0] HI_MASK =
        ~((INST_ADDR_W'(1) << (AW + 2)) - INST_ADDR_W'(1));

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [AW-1:0]     clr_cnt;
    logic [AW-1:0]     clr_cnt_nxt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     wr_ptr_nxt;
    logic              oob_err_nxt;
    logic              ld_done_nxt;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [INST_W-1:0] ram_wdata;
    logic [INST_W-1:0] ram_rdata;
    logic              fetch_oob;

    assign fetch_oob = rom_en && (|(rom_addr & HI_MASK));

    // Next-state, counter and write-port decode.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_ptr_nxt  = wr_ptr;
        oob_err_nxt = oob_err;
        ld_done_nxt = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = clr_cnt;
        ram_wdata   = ZERO_WORD;

        case (state)
            ST_CLEAR: begin
                ram_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (&clr_cnt) begin
                    state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (fetch_oob) begin
                    oob_err_nxt = 1'b1;
                end
                if (ld_start) begin
                    wr_ptr_nxt = ld_base;
                    state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    ram_we     = 1'b1;
                    ram_waddr  = wr_ptr;
                    ram_wdata  = ld_data;
                    wr_ptr_nxt = wr_ptr + AW'(1);
                    if (ld_last) begin
                        state_nxt   = ST_SERVE;
                        ld_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase

        // Reset wins over any write requested in the same cycle.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            wr_ptr  <= '0;
            oob_err <= 1'b0;
            ld_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            wr_ptr  <= wr_ptr_nxt;
            oob_err <= oob_err_nxt;
            ld_done <= ld_done_nxt;
        end
    end

    assign cpu_hold = (state != ST_SERVE);
    assign ld_ready = (state == ST_LOAD);
    assign rom_data = ((state == ST_SERVE) && rom_en && !fetch_oob) ? ram_rdata : ZERO_WORD;

    inst_ram #(
        .AW (AW)
    ) u_inst_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rom_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: clear timing, load bursts, wrap, out-of-range fetch, reset abort.
module tb_inst_rom_resp;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rom_en;
    logic [31:0]   rom_addr;
    logic [31:0]   rom_data;
    logic          cpu_hold;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          ld_done;
    logic          oob_err;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    inst_rom_resp #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cpu_hold (cpu_hold),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .oob_err  (oob_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Counts hold cycles after reset release; also watches for stray ld_ready/ld_done.
    task automatic wait_clear(input string tag, input logic pulse_start);
        int n = 0;
        int stray = 0;
        while (cpu_hold && n < 2000) begin
            n++;
            ld_start = pulse_start && (n == 100);
            if (ld_ready || ld_done) stray++;
            tick();
        end
        ld_start = 1'b0;
        check({tag, "_hold_cycles"}, 32'(n), 32'd1024);
        check({tag, "_stray_ready_done"}, 32'(stray), 32'd0);
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 32'hBBBB_0001};
        vecs[1] = '{1'b1, 32'h0000_0004, 32'h2402_0002};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'h0022_1820};
        vecs[3] = '{1'b1, 32'h0000_000B, 32'h0022_1820};
        vecs[4] = '{1'b1, 32'h0000_0007, 32'h2402_0002};
        vecs[5] = '{1'b1, 32'h0000_0FFC, 32'hAAAA_0000};
        vecs[6] = '{1'b1, 32'h0000_0FFF, 32'hAAAA_0000};
        vecs[7] = '{1'b1, 32'h0000_0010, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
        vecs[9] = '{1'b1, 32'h0000_0FF8, 32'h0000_0000};

        rst = 1'b1; rom_en = 1'b1; rom_addr = 32'h0;
        ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        tick();
        tick();
        #1;
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_oob", 32'(oob_err), 32'd0);
        check("rst_data", rom_data, 32'h0);
        rst = 1'b0;
        wait_clear("clear1", 1'b1);

        rom_en = 1'b1; rom_addr = 32'h0000_0010;
        #1;
        check("post_clear_fetch10", rom_data, 32'h0);

        // First burst at base 0 with an ignored ld_last-only cycle and an ignored ld_start.
        ld_start = 1'b1; ld_base = '0; rom_addr = 32'h0;
        #1;
        check("start_cycle_ready", 32'(ld_ready), 32'd0);
        tick();
        ld_start = 1'b0;
        #1;
        check("load_ready", 32'(ld_ready), 32'd1);
        check("load_hold", 32'(cpu_hold), 32'd1);
        ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        #1;
        check("last_no_valid_ready", 32'(ld_ready), 32'd1);
        check("last_no_valid_done", 32'(ld_done), 32'd0);
        load_word(32'h2401_0001, 1'b0);
        ld_start = 1'b1; ld_base = 10'h155;
        load_word(32'h2402_0002, 1'b0);
        ld_start = 1'b0;
        load_word(32'h0022_1820, 1'b1);
        #1;
        check("b1_done", 32'(ld_done), 32'd1);
        check("b1_hold", 32'(cpu_hold), 32'd0);
        check("b1_ready", 32'(ld_ready), 32'd0);
        rom_addr = 32'h0;
        #1 check("b1_fetch0", rom_data, 32'h2401_0001);
        rom_addr = 32'h4;
        #1 check("b1_fetch4", rom_data, 32'h2402_0002);
        rom_addr = 32'h8;
        #1 check("b1_fetch8", rom_data, 32'h0022_1820);
        tick();
        #1;
        check("b1_done_pulse_end", 32'(ld_done), 32'd0);
        check("b1_no_extra_burst", 32'(cpu_hold), 32'd0);

        // Wrap burst: 0x3FF then 0.
        ld_start = 1'b1; ld_base = 10'h3FF;
        tick();
        ld_start = 1'b0;
        load_word(32'hAAAA_0000, 1'b0);
        load_word(32'hBBBB_0001, 1'b1);
        #1 check("b2_done", 32'(ld_done), 32'd1);

        for (int i = 0; i < 10; i++) begin
            rom_en   = vecs[i].en;
            rom_addr = vecs[i].addr;
            #1;
            check($sformatf("vec%0d_data", i), rom_data, vecs[i].exp);
            tick();
        end
        check("vec_oob_clear", 32'(oob_err), 32'd0);

        // Out-of-range fetch sets a sticky error.
        rom_en = 1'b1; rom_addr = 32'h0000_1000;
        #1 check("oob_data", rom_data, 32'h0);
        check("oob_before_edge", 32'(oob_err), 32'd0);
        tick();
        rom_addr = 32'h0000_0004;
        #1 check("oob_set", 32'(oob_err), 32'd1);
        check("oob_inrange_after", rom_data, 32'h2402_0002);
        rom_addr = 32'h8000_0000;
        #1 check("oob_high_data", rom_data, 32'h0);
        tick();
        tick();
        #1 check("oob_sticky", 32'(oob_err), 32'd1);

        // Gapped burst aborted by reset after the second word.
        rom_addr = 32'h0;
        ld_start = 1'b1; ld_base = '0;
        tick();
        ld_start = 1'b0;
        load_word(32'h1111_1111, 1'b0);
        for (int g = 0; g < 3; g++) begin
            #1 check($sformatf("gap%0d_ready", g), 32'(ld_ready), 32'd1);
            tick();
        end
        load_word(32'h2222_2222, 1'b0);
        tick();
        tick();
        #1 check("gap_no_done", 32'(ld_done), 32'd0);
        check("gap_oob_kept", 32'(oob_err), 32'd1);
        rst = 1'b1; ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h3333_3333;
        tick();
        rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        check("abort_done", 32'(ld_done), 32'd0);
        check("abort_ready", 32'(ld_ready), 32'd0);
        check("abort_hold", 32'(cpu_hold), 32'd1);
        check("abort_oob", 32'(oob_err), 32'd0);
        wait_clear("clear2", 1'b0);
        rom_addr = 32'h0;
        #1 check("clr2_fetch0", rom_data, 32'h0);
        rom_addr = 32'h4;
        #1 check("clr2_fetch4", rom_data, 32'h0);
        rom_addr = 32'hFFC;
        #1 check("clr2_fetchffc", rom_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 Parameter AW, default 10, word-address width; depth = 2^AW 32-bit words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rom_en  input  1  fetch enable from CPU fetch stage.
REQ-005 rom_addr  input  `InstAddrBus (32)  byte address of instruction.
REQ-006 rom_data  output  `InstBus (32)  instruction returned to CPU.
REQ-007 cpu_hold  output  1  high = memory not serving; CPU must stall.
REQ-008 ld_start  input  1  one-cycle pulse opening a program-load burst.
REQ-009 ld_base  input  AW  word address of first loaded word.
REQ-010 ld_valid  input  1  load word present.
REQ-011 ld_data  input  32  load word.
REQ-012 ld_last  input  1  qualifies final word of burst.
REQ-013 ld_ready  output  1  block accepts load word.
REQ-014 ld_done  output  1  one-cycle pulse after final word written.
REQ-015 oob_err  output  1  sticky: fetch hit an address beyond depth.

Function
REQ-016 FSM states CLEAR, SERVE, LOAD; one state active at a time.
REQ-017 CLEAR: writes 0x00000000 to word clr_cnt each cycle, clr_cnt 0..2^AW-1; after writing last word -> SERVE next cycle.
REQ-018 SERVE: rom_data combinational = mem[rom_addr[AW+1:2]] when rom_en=1 and rom_addr[31:AW+2]==0; else 0x00000000 (ZeroWord/NOP), same cycle (zero-latency read).
REQ-019 rom_addr[1:0] ignored.
REQ-020 rom_en=1 with rom_addr[31:AW+2]!=0 in SERVE: rom_data=0, oob_err set next edge, held until rst.
REQ-021 SERVE and ld_start=1: wr_ptr<=ld_base, -> LOAD next cycle; fetch in that cycle served normally.
REQ-022 ld_start ignored in CLEAR and LOAD.
REQ-023 LOAD: ld_ready=1; transfer when ld_valid&ld_ready; mem[wr_ptr]<=ld_data, wr_ptr<=wr_ptr+1 modulo 2^AW (wrap 2^AW-1 -> 0).
REQ-024 LOAD transfer with ld_last=1: word written, -> SERVE, ld_done=1 for the following cycle only.
REQ-025 ld_last without ld_valid has no effect.
REQ-026 ld_valid=0 in LOAD: state held indefinitely, no write.
REQ-027 cpu_hold = (state != SERVE); rom_data=0 whenever cpu_hold=1.
REQ-028 ld_ready=0 outside LOAD.

Reset
REQ-029 rst=1 at a clock edge: state<=CLEAR, clr_cnt<=0, wr_ptr<=0, oob_err<=0, ld_done<=0; cpu_hold=1, ld_ready=0, rom_data=0 from that edge.
REQ-030 rst mid-LOAD aborts burst: no ld_done; words already written are cleared by CLEAR sequence.
REQ-031 rst dominates every input in the same cycle.

Structure
REQ-032 `InstBus, `InstAddrBus, `ZeroWord and the three state encodings live in the shared defines header.
REQ-033 Storage in sub-module inst_ram: 2^AW x 32, one synchronous write port, one asynchronous read port; FSM, counters and flags in inst_rom_resp.

Verification
REQ-034 Reset then idle: cpu_hold=1 for exactly 1024 cycles (AW=10), then 0; fetch rom_addr=0x0000_0010 -> rom_data=0x00000000.
REQ-035 ld_start, ld_base=0, words 0x24010001,0x24020002,0x00221820 (last on 3rd) -> ld_done one cycle after 3rd transfer; fetch 0x0,0x4,0x8 return those words same cycle.
REQ-036 ld_base=0x3FF, two words 0xAAAA0000,0xBBBB0001 -> written to words 1023 and 0 (wrap); fetch 0x0FFC=0xAAAA0000, 0x0000=0xBBBB0001.
REQ-037 Fetch rom_addr=0x0000_1000 (AW=10) -> rom_data=0, oob_err=1 next cycle, stays 1 until rst.
REQ-038 LOAD with ld_valid gaps of 3 cycles and rst asserted after 2nd word -> no ld_done, CLEAR restarts, fetch 0x0 after clear returns 0.
REQ-039 ld_start during CLEAR and during LOAD -> ignored; ld_ready timing unchanged, no extra burst.
